// File: rtl/tone_seq_pkg.sv
// Shared types and note-table field layout for the tone sequencer.
// Entry layout, LSB first: dur[DUR_W], sel[3], rest, last.
package tone_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    localparam int DUR_LSB = 0;

    function automatic int SEL_LSB(input int dur_w);
        return DUR_LSB + dur_w;
    endfunction

    function automatic int REST_BIT(input int dur_w);
        return SEL_LSB(dur_w) + 3;
    endfunction

    function automatic int LAST_BIT(input int dur_w);
        return REST_BIT(dur_w) + 1;
    endfunction

    function automatic int ENTRY_W(input int dur_w);
        return LAST_BIT(dur_w) + 1;
    endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Control/register side of the tone sequencer: playback control,
// note-table write port and status back to the register block.
interface tone_sequencer_if
    import tone_seq_pkg::*;
#(
    parameter int AW = 4,
    parameter int EW = ENTRY_W(8)
);
    logic          start;
    logic          stop;
    logic          loop;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [EW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic [AW-1:0] note_idx;

    modport master (
        output start, stop, loop, wr_en, wr_addr, wr_data,
        input  busy, done, note_idx
    );

    modport slave (
        input  start, stop, loop, wr_en, wr_addr, wr_data,
        output busy, done, note_idx
    );
endinterface

// File: rtl/tone_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV cycles while run=1.
// clr restarts the count so the next tick is a full period away.
module tone_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          term;

    assign term = cnt_q == CW'(DIV - 1);
    assign tick = run && term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= term ? '0 : cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/tone_sequencer.sv
// Tone sequencer: steps a writable note table onto the tone path sel/en.
// Optional macro TONE_SEQ_PAUSE_EN adds a pause input that freezes a note.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int CLK_HZ    = 100000000,
    parameter int TICK_HZ   = 100,
    parameter int DEPTH     = 16,
    parameter int DUR_W     = 8,
    parameter int GAP_TICKS = 2
) (
    input  logic           clk,
    input  logic           rst,
`ifdef TONE_SEQ_PAUSE_EN
    input  logic           pause,
`endif
    tone_sequencer_if.slave bus,
    output logic [2:0]     sel,
    output logic           en
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = ENTRY_W(DUR_W);
    localparam int SL = SEL_LSB(DUR_W);
    localparam int RB = REST_BIT(DUR_W);
    localparam int LB = LAST_BIT(DUR_W);
    localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    state_t         state_q, state_d, adv_st;
    logic [AW-1:0]  idx_q, idx_d, adv_idx;
    logic           fph_q;
    logic [EW-1:0]  mem [DEPTH];
    logic [EW-1:0]  rd_q;
    logic [DUR_W-1:0] dcnt_q;
    logic [GW-1:0]  gcnt_q;
    logic [2:0]     sel_q;
    logic           last_q, mute_q;
    logic           hold, run, tick, clr;
    logic           play_end, gap_end;

`ifdef TONE_SEQ_PAUSE_EN
    assign hold = pause && (state_q == S_PLAY || state_q == S_GAP);
`else
    assign hold = 1'b0;
`endif

    assign run = (state_q == S_PLAY || state_q == S_GAP) && !hold;
    assign clr = state_d != state_q;

    tone_tick_gen #(
        .DIV(CLK_HZ / TICK_HZ)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .run (run),
        .tick(tick)
    );

    assign play_end = !hold &&
        (dcnt_q == '0 || (tick && dcnt_q == DUR_W'(1)));
    assign gap_end = tick && gcnt_q == GW'(1);

    always_comb begin
        adv_st  = S_FETCH;
        adv_idx = idx_q + AW'(1);
        if (last_q || idx_q == AW'(DEPTH - 1)) begin
            adv_st  = bus.loop ? S_FETCH : S_DONE;
            adv_idx = bus.loop ? '0 : idx_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                end
            end
            S_FETCH: begin
                if (fph_q) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (play_end) begin
                    if (GAP_TICKS == 0) begin
                        state_d = adv_st;
                        idx_d   = adv_idx;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    state_d = adv_st;
                    idx_d   = adv_idx;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.stop) begin
            state_d = S_IDLE;
            idx_d   = idx_q;
        end
    end

    // Table RAM: first FETCH cycle issues the read, second latches fields
    always_ff @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
        if (state_q == S_FETCH && !fph_q) rd_q <= mem[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            fph_q   <= 1'b0;
            dcnt_q  <= '0;
            gcnt_q  <= '0;
            sel_q   <= '0;
            last_q  <= 1'b0;
            mute_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fph_q   <= state_q == S_FETCH && state_d == S_FETCH;
            if (state_q == S_FETCH && state_d == S_PLAY) begin
                sel_q  <= rd_q[SL +: 3];
                last_q <= rd_q[LB];
                dcnt_q <= rd_q[DUR_LSB +: DUR_W];
                mute_q <= rd_q[RB] || rd_q[DUR_LSB +: DUR_W] == '0;
            end else if (state_q == S_PLAY && tick && dcnt_q != '0) begin
                dcnt_q <= dcnt_q - DUR_W'(1);
            end
            if (state_q != S_GAP && state_d == S_GAP) begin
                gcnt_q <= GW'(GAP_TICKS);
            end else if (state_q == S_GAP && tick) begin
                gcnt_q <= gcnt_q - GW'(1);
            end
        end
    end

    assign sel          = sel_q;
    assign en           = state_q == S_PLAY && !mute_q && !hold;
    assign bus.busy     = state_q != S_IDLE;
    assign bus.done     = state_q == S_DONE;
    assign bus.note_idx = idx_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer at 10 clk per tick, 2-tick gap.
// Pause scenario runs only when TONE_SEQ_PAUSE_EN is defined.
module tb_tone_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sel;
    logic       en;
`ifdef TONE_SEQ_PAUSE_EN
    logic       pause;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic       en_tr   [200];
    logic [2:0] sel_tr  [200];
    logic       busy_tr [200];
    logic       done_tr [200];
    logic [3:0] idx_tr  [200];

    tone_sequencer_if #(.AW(4), .EW(13)) bus ();

    tone_sequencer #(
        .CLK_HZ   (1000),
        .TICK_HZ  (100),
        .DEPTH    (16),
        .DUR_W    (8),
        .GAP_TICKS(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef TONE_SEQ_PAUSE_EN
        .pause(pause),
`endif
        .bus  (bus),
        .sel  (sel),
        .en   (en)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [12:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic kick();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic halt();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            en_tr[k]   = en;
            sel_tr[k]  = sel;
            busy_tr[k] = bus.busy;
            done_tr[k] = bus.done;
            idx_tr[k]  = bus.note_idx;
            step();
        end
    endtask

    function automatic int cnt_en(input int a, input int b);
        int c = 0;
        for (int k = a; k <= b; k++) if (en_tr[k]) c++;
        return c;
    endfunction

    function automatic int cnt_done(input int a, input int b);
        int c = 0;
        for (int k = a; k <= b; k++) if (done_tr[k]) c++;
        return c;
    endfunction

    function automatic int cnt_busy(input int a, input int b);
        int c = 0;
        for (int k = a; k <= b; k++) if (busy_tr[k]) c++;
        return c;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if (en !== 1'b0) begin
            n_err++; $display("FAIL reset_en: got %b want 0", en);
        end
        n_cmp++;
        if (sel !== 3'd0) begin
            n_err++; $display("FAIL reset_sel: got %0d want 0", sel);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_err++; $display("FAIL reset_done: got %b want 0", bus.done);
        end
        n_cmp++;
        if (bus.note_idx !== 4'd0) begin
            n_err++; $display("FAIL reset_idx: got %0d want 0", bus.note_idx);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic load_basic();
        wr(4'd0, {1'b0, 1'b0, 3'd5, 8'd3});
        wr(4'd1, {1'b1, 1'b0, 3'd2, 8'd1});
    endtask

    task automatic test_basic();
        load_basic();
        kick();
        capture(91);
        n_cmp++;
        if (busy_tr[0] !== 1'b1) begin
            n_err++; $display("FAIL basic_busy: got %b want 1", busy_tr[0]);
        end
        n_cmp++;
        if (en_tr[1] !== 1'b0) begin
            n_err++; $display("FAIL basic_en_early: got %b want 0", en_tr[1]);
        end
        n_cmp++;
        if (en_tr[2] !== 1'b1 || sel_tr[2] !== 3'd5) begin
            n_err++;
            $display("FAIL basic_note0: got en=%b sel=%0d want en=1 sel=5",
                     en_tr[2], sel_tr[2]);
        end
        n_cmp++;
        if (cnt_en(2, 31) !== 30) begin
            n_err++; $display("FAIL basic_len0: got %0d want 30", cnt_en(2, 31));
        end
        n_cmp++;
        if (cnt_en(32, 53) !== 0 || sel_tr[40] !== 3'd5) begin
            n_err++;
            $display("FAIL basic_gap0: got en_cnt=%0d sel=%0d want 0 and 5",
                     cnt_en(32, 53), sel_tr[40]);
        end
        n_cmp++;
        if (idx_tr[52] !== 4'd1) begin
            n_err++; $display("FAIL basic_idx1: got %0d want 1", idx_tr[52]);
        end
        n_cmp++;
        if (sel_tr[54] !== 3'd2 || cnt_en(54, 63) !== 10) begin
            n_err++;
            $display("FAIL basic_note1: got sel=%0d en_cnt=%0d want 2 and 10",
                     sel_tr[54], cnt_en(54, 63));
        end
        n_cmp++;
        if (cnt_en(64, 90) !== 0) begin
            n_err++; $display("FAIL basic_gap1: got %0d want 0", cnt_en(64, 90));
        end
        n_cmp++;
        if (done_tr[84] !== 1'b1 || cnt_done(0, 90) !== 1) begin
            n_err++;
            $display("FAIL basic_done: got at84=%b count=%0d want 1 and 1",
                     done_tr[84], cnt_done(0, 90));
        end
        n_cmp++;
        if (busy_tr[85] !== 1'b0) begin
            n_err++; $display("FAIL basic_idle: got %b want 0", busy_tr[85]);
        end
    endtask

    task automatic test_loop();
        load_basic();
        bus.loop = 1'b1;
        kick();
        capture(91);
        n_cmp++;
        if (idx_tr[84] !== 4'd0 || busy_tr[84] !== 1'b1) begin
            n_err++;
            $display("FAIL loop_wrap: got idx=%0d busy=%b want 0 and 1",
                     idx_tr[84], busy_tr[84]);
        end
        n_cmp++;
        if (sel_tr[86] !== 3'd5 || en_tr[86] !== 1'b1) begin
            n_err++;
            $display("FAIL loop_replay: got sel=%0d en=%b want 5 and 1",
                     sel_tr[86], en_tr[86]);
        end
        n_cmp++;
        if (cnt_done(0, 90) !== 0) begin
            n_err++; $display("FAIL loop_nodone: got %0d want 0", cnt_done(0, 90));
        end
        halt();
        n_cmp++;
        if (en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL loop_stop: got en=%b busy=%b done=%b want 0 0 0",
                     en, bus.busy, bus.done);
        end
        step();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.note_idx !== 4'd0) begin
            n_err++;
            $display("FAIL loop_after_stop: got done=%b idx=%0d want 0 and 0",
                     bus.done, bus.note_idx);
        end
        bus.loop = 1'b0;
    endtask

    task automatic test_rest();
        wr(4'd0, {1'b1, 1'b1, 3'd3, 8'd4});
        kick();
        capture(70);
        n_cmp++;
        if (cnt_busy(0, 69) !== 63) begin
            n_err++; $display("FAIL rest_busy: got %0d want 63", cnt_busy(0, 69));
        end
        n_cmp++;
        if (cnt_en(0, 69) !== 0) begin
            n_err++; $display("FAIL rest_en: got %0d want 0", cnt_en(0, 69));
        end
        n_cmp++;
        if (done_tr[62] !== 1'b1 || cnt_done(0, 69) !== 1) begin
            n_err++;
            $display("FAIL rest_done: got at62=%b count=%0d want 1 and 1",
                     done_tr[62], cnt_done(0, 69));
        end
    endtask

    task automatic test_dur_zero();
        wr(4'd0, {1'b0, 1'b0, 3'd4, 8'd0});
        wr(4'd1, {1'b1, 1'b0, 3'd7, 8'd1});
        kick();
        capture(60);
        n_cmp++;
        if (sel_tr[2] !== 3'd4 || en_tr[2] !== 1'b0) begin
            n_err++;
            $display("FAIL dur0_play: got sel=%0d en=%b want 4 and 0",
                     sel_tr[2], en_tr[2]);
        end
        n_cmp++;
        if (cnt_en(0, 24) !== 0 || idx_tr[22] !== 4'd0 || idx_tr[23] !== 4'd1) begin
            n_err++;
            $display("FAIL dur0_gap: got en=%0d idx22=%0d idx23=%0d want 0 0 1",
                     cnt_en(0, 24), idx_tr[22], idx_tr[23]);
        end
        n_cmp++;
        if (sel_tr[25] !== 3'd7 || cnt_en(25, 34) !== 10 || en_tr[35] !== 1'b0) begin
            n_err++;
            $display("FAIL dur0_note1: got sel=%0d cnt=%0d en35=%b want 7 10 0",
                     sel_tr[25], cnt_en(25, 34), en_tr[35]);
        end
        n_cmp++;
        if (done_tr[55] !== 1'b1) begin
            n_err++; $display("FAIL dur0_done: got %b want 1", done_tr[55]);
        end
    endtask

    task automatic test_back_to_back();
        load_basic();
        kick();
        for (int k = 0; k < 10; k++) step();
        kick();
        n_cmp++;
        if (en !== 1'b1 || bus.note_idx !== 4'd0 || sel !== 3'd5) begin
            n_err++;
            $display("FAIL restart_ignored: got en=%b idx=%0d sel=%0d want 1 0 5",
                     en, bus.note_idx, sel);
        end
        for (int k = 0; k < 43; k++) step();
        n_cmp++;
        if (sel !== 3'd2 || en !== 1'b1 || bus.note_idx !== 4'd1) begin
            n_err++;
            $display("FAIL restart_progress: got sel=%0d en=%b idx=%0d want 2 1 1",
                     sel, en, bus.note_idx);
        end
        halt();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        step();
        n_cmp++;
        if (bus.busy !== 1'b0 || en !== 1'b0) begin
            n_err++;
            $display("FAIL start_stop: got busy=%b en=%b want 0 0", bus.busy, en);
        end
    endtask

    task automatic test_async_reset();
        load_basic();
        kick();
        for (int k = 0; k < 5; k++) step();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (en !== 1'b0 || bus.busy !== 1'b0 || sel !== 3'd0) begin
            n_err++;
            $display("FAIL async_rst: got en=%b busy=%b sel=%0d want 0 0 0",
                     en, bus.busy, sel);
        end
        step();
        rst = 1'b0;
        step();
    endtask

`ifdef TONE_SEQ_PAUSE_EN
    task automatic test_pause();
        int hi;
        logic en20;
        logic d;
        hi = 0;
        en20 = 1'b1;
        d = 1'b0;
        load_basic();
        kick();
        for (int k = 0; k < 150; k++) begin
            pause = (k >= 10 && k < 35);
            #1;
            if (k < 57 && en) hi++;
            if (k == 20) en20 = en;
            if (bus.done) d = 1'b1;
            @(posedge clk);
            #1;
        end
        pause = 1'b0;
        n_cmp++;
        if (en20 !== 1'b0) begin
            n_err++; $display("FAIL pause_en: got %b want 0", en20);
        end
        n_cmp++;
        if (hi !== 30) begin
            n_err++; $display("FAIL pause_len: got %0d want 30", hi);
        end
        n_cmp++;
        if (d !== 1'b1) begin
            n_err++; $display("FAIL pause_done: got %b want 1", d);
        end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.loop    = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
`ifdef TONE_SEQ_PAUSE_EN
        pause       = 1'b0;
`endif
        test_reset();
        test_basic();
        test_loop();
        test_rest();
        test_dur_zero();
        test_back_to_back();
        test_async_reset();
`ifdef TONE_SEQ_PAUSE_EN
        test_pause();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Controller for the audio tone path. It drives that path's 3-bit frequency select (`sel`) and enable (`en`) from a small writable note table, so a melody plays without CPU involvement.
- Each table entry gives a tone select, a rest flag, a duration in ticks and a last-note flag. The block steps through entries with a fixed silent gap between notes, then stops or loops.
- Sits between the control/register logic and the tone generator.

Parameters:
- CLK_HZ, 100000000, input clock frequency.
- TICK_HZ, 100, duration time base (10 ms per tick at defaults); CLK_HZ/TICK_HZ must be an integer >= 2.
- DEPTH, 16, note table entries (power of 2); AW = clog2(DEPTH).
- DUR_W, 8, duration field width in ticks.
- GAP_TICKS, 2, silent ticks after every note; 0 = no gap.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin playback at entry 0; ignored while busy.
- stop  in  1  abort playback.
- loop  in  1  sampled at each last-note gap end; 1 = restart at entry 0.
- wr_en  in  1  table write strobe.
- wr_addr  in  AW  table write address.
- wr_data  in  DUR_W+5  {last[1], rest[1], sel[3], dur[DUR_W]}.
- sel  out  3  tone select to the tone generator.
- en  out  1  tone/amp enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on natural completion.
- note_idx  out  AW  index of the entry currently playing.

Behaviour:
- Reset (async, rst=1):
  - sel=0, en=0, busy=0, done=0, note_idx=0.
  - State=IDLE, prescaler=0.
  - Table contents are not reset.
- Table:
  - Synchronous write on wr_en, allowed in any state.
  - Registered read: one-cycle latency.
  - A write to an entry not yet fetched takes effect on that entry. A write to the entry already fetched does not affect the current note.
- States: IDLE, FETCH, PLAY, GAP, DONE.
  - IDLE: en=0. On start=1 and stop=0: idx<=0, go to FETCH, busy=1 next cycle.
  - FETCH: issue read of idx; go to PLAY next cycle, latching the entry fields.
    - Latency: start sampled at edge N, en rises at edge N+2.
  - PLAY:
    - sel=entry.sel; en = !entry.rest.
    - Duration counter loaded with dur; prescaler restarted on entry, so the first tick is a full period.
    - Each tick decrements the counter. At count 0, go to GAP, or straight to the advance step if GAP_TICKS=0.
    - dur=0: PLAY lasts exactly 1 cycle. en is not asserted (forced 0), then advance as normal.
  - GAP: en=0, sel held; lasts GAP_TICKS ticks, then the advance step.
  - Advance step:
    - If entry.last=1 or idx=DEPTH-1: loop=1 goes to FETCH with idx=0; otherwise DONE.
    - Otherwise idx<=idx+1 and FETCH.
  - DONE: done=1 for one cycle, en=0; then IDLE, busy=0.
- Stop:
  - stop=1 in any state: IDLE on the next edge, en=0, no done pulse, note_idx holds its last value.
  - start and stop asserted together: stop wins.
- start while busy: ignored, no restart.
- Tick: prescaler counts 0..CLK_HZ/TICK_HZ-1 and emits a one-cycle tick at the terminal count. It runs only in PLAY and GAP and clears on every state entry.
- Widths: duration counter is DUR_W bits, decrement only, never underflows. GAP counter is clog2(GAP_TICKS+1) bits.
- sel changes only on entry to PLAY, so the tone generator never sees a mid-note glitch.

Optional Feature:
- Macro: TONE_SEQ_PAUSE_EN.
- Defined:
  - Adds input `pause` (1 bit).
  - While pause=1 and state is PLAY or GAP: prescaler, duration and gap counters freeze, en=0, sel holds.
  - On release, the note resumes with its remaining time.
  - pause is ignored in IDLE/FETCH/DONE.
  - stop overrides pause.
- Undefined: no pause port, no freeze logic.

Decomposition:
- Package tone_seq_pkg holds:
  - state enum;
  - entry field bit positions (DUR_LSB, SEL_LSB, REST_BIT, LAST_BIT);
  - ENTRY_W function of DUR_W.
- One sub-module, tone_tick_gen: parameterised prescaler with a clear input and a one-cycle tick output.

Test Plan:
- Bench parameters throughout: CLK_HZ=1000, TICK_HZ=100 (10 clk/tick), GAP_TICKS=2, DEPTH=16.
- Entries {0,0,3'd5,8'd3}, {1,0,3'd2,8'd1}; start -> en high 2 cycles after start with sel=5 for 30 clk; en low 20 clk; sel=2, en high 10 clk; en low 20 clk; done pulse 1 cycle; busy falls.
- Same table with loop=1 -> after entry 1's gap, note_idx=0 and sel=5 again; stop then gives en=0 next cycle, busy=0, no done.
- Entry 0 rest=1, dur=4, last=1 -> busy for 1+1+40+20 cycles plus DONE, en never asserted, done pulses.
- Entry 0 dur=0, entry 1 sel=7, dur=1, last=1 -> entry 0 PLAY is 1 cycle with en=0; then 20 clk gap; sel=7 for 10 clk.
- start during PLAY -> ignored, note_idx unchanged. start+stop same cycle from IDLE -> stays IDLE. Async rst mid-PLAY -> en=0, busy=0 immediately.
- With TONE_SEQ_PAUSE_EN, pause=1 for 25 clk mid-note (dur=3) -> en low during pause; total en-high time still 30 clk.
